// File: rtl/vga_scan_driver_if.sv
// ---------------------------------------------------------------------------
// vga_scan_driver_if
//   Pixel interface between the VGA scan driver (timing master) and the
//   image generator that returns a colour for the current scan position.
//
//   Hindex       : horizontal scan counter, 0..H_TOT-1
//   Vindex       : vertical scan counter, 0..V_TOT-1
//   canvas_valid : current (Hindex, Vindex) lies inside the visible canvas
//   frame_start  : one-clock pulse when the scan wraps back to (0,0)
//   pixel_data   : {R[11:8], G[7:4], B[3:0]} for the current coordinates,
//                  combinational from the image generator
//
//   master : scan driver side, produces coordinates and consumes colour
//   slave  : image generator side
// ---------------------------------------------------------------------------
interface vga_scan_driver_if;
    logic [11:0] Hindex;
    logic [11:0] Vindex;
    logic        canvas_valid;
    logic        frame_start;
    logic [11:0] pixel_data;

    modport master (
        output Hindex,
        output Vindex,
        output canvas_valid,
        output frame_start,
        input  pixel_data
    );

    modport slave (
        input  Hindex,
        input  Vindex,
        input  canvas_valid,
        input  frame_start,
        output pixel_data
    );
endinterface

// File: rtl/vga_scan_driver.sv
// ---------------------------------------------------------------------------
// vga_scan_driver
//   Generates 800x600 @ 72 Hz VGA scan timing from a 100 MHz clock with a
//   divide-by-two pixel enable (50 MHz pixel rate). Publishes the scan
//   position to the image generator, samples the colour it returns and
//   registers colour, HSYNC and VSYNC together onto the VGA pins, so all
//   three lag the coordinates by exactly one pixel.
//
// Ports
//   CLK100MHZ      in   system clock
//   CPU_RESETN     in   synchronous active-low reset
//   pix_if         master modport of vga_scan_driver_if
//                  (Hindex, Vindex, canvas_valid, frame_start out;
//                   pixel_data in)
//   VGA_R/G/B      out  registered 4-bit colour channels
//   VGA_HS/VGA_VS  out  registered syncs, active level SYNC_POL
//
// Configuration
//   VGA_BORDER_EN  when defined, the outermost row/column of the visible
//                  canvas is forced to white (12'hFFF) for monitor
//                  alignment. Undefined: visible colour is pixel_data.
// ---------------------------------------------------------------------------
module vga_scan_driver #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 56,
    parameter int H_SYNC   = 120,
    parameter int H_BP     = 64,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 37,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 23,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic               CLK100MHZ,
    input  logic               CPU_RESETN,
    vga_scan_driver_if.master  pix_if,
    output logic [3:0]         VGA_R,
    output logic [3:0]         VGA_G,
    output logic [3:0]         VGA_B,
    output logic               VGA_HS,
    output logic               VGA_VS
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST     = 12'(H_TOT - 1);
    localparam logic [11:0] V_LAST     = 12'(V_TOT - 1);
    localparam logic [11:0] H_VIS      = 12'(H_ACTIVE);
    localparam logic [11:0] V_VIS      = 12'(V_ACTIVE);
    localparam logic [11:0] HS_FIRST   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_LAST    = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [11:0] VS_FIRST   = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_LAST    = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
`ifdef VGA_BORDER_EN
    localparam logic [11:0] H_VIS_LAST = 12'(H_ACTIVE - 1);
    localparam logic [11:0] V_VIS_LAST = 12'(V_ACTIVE - 1);
`endif

    // State
    logic        div_q,   div_d;
    logic [11:0] h_q,     h_d;
    logic [11:0] v_q,     v_d;
    logic [11:0] rgb_q,   rgb_d;
    logic        hs_q,    hs_d;
    logic        vs_q,    vs_d;
    logic        fs_q,    fs_d;

    // Decodes of the current (registered) scan position
    logic        pix_ce;
    logic        h_wrap;
    logic        v_wrap;
    logic        visible;
    logic        in_hs;
    logic        in_vs;

    always_comb begin
        pix_ce  = div_q;
        h_wrap  = (h_q == H_LAST);
        v_wrap  = (v_q == V_LAST);
        visible = (h_q < H_VIS) && (v_q < V_VIS);
        in_hs   = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
        in_vs   = (v_q >= VS_FIRST) && (v_q <= VS_LAST);

        div_d = ~div_q;
        h_d   = h_q;
        v_d   = v_q;
        rgb_d = rgb_q;
        hs_d  = hs_q;
        vs_d  = vs_q;

        // Registered on the last pixel of the frame so the pulse lines up
        // with the first cycle in which the counters read (0,0). The
        // following edge has no pix_ce, so the pulse is one cycle wide.
        fs_d  = pix_ce && h_wrap && v_wrap;

        if (pix_ce) begin
            h_d = h_wrap ? 12'd0 : h_q + 12'd1;
            if (h_wrap) begin
                v_d = v_wrap ? 12'd0 : v_q + 12'd1;
            end

            // Output stage samples the colour and syncs of the pixel being
            // left, giving a uniform one-pixel lag on colour, HS and VS.
            rgb_d = visible ? pix_if.pixel_data : 12'h000;
`ifdef VGA_BORDER_EN
            // Border is drawn only inside the canvas; blanking stays black.
            if (visible && ((h_q == 12'd0) || (h_q == H_VIS_LAST) ||
                            (v_q == 12'd0) || (v_q == V_VIS_LAST))) begin
                rgb_d = 12'hFFF;
            end
`endif
            hs_d = in_hs ? SYNC_POL : ~SYNC_POL;
            vs_d = in_vs ? SYNC_POL : ~SYNC_POL;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            div_q <= 1'b0;
            h_q   <= 12'd0;
            v_q   <= 12'd0;
            rgb_q <= 12'h000;
            hs_q  <= ~SYNC_POL;
            vs_q  <= ~SYNC_POL;
            fs_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
            rgb_q <= rgb_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            fs_q  <= fs_d;
        end
    end

    assign pix_if.Hindex       = h_q;
    assign pix_if.Vindex       = v_q;
    assign pix_if.canvas_valid = visible;
    assign pix_if.frame_start  = fs_q;

    assign VGA_R  = rgb_q[11:8];
    assign VGA_G  = rgb_q[7:4];
    assign VGA_B  = rgb_q[3:0];
    assign VGA_HS = hs_q;
    assign VGA_VS = vs_q;

endmodule

// File: tb/tb_vga_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_vga_scan_driver
//   Two instances share clock, reset and pixel_data: u0 with the standard
//   800x600 timing (line-level behaviour) and u1 with a shrunken raster and
//   negative syncs so whole frames, vertical sync and frame_start fit in a
//   short run. The reference model derives every output from the number of
//   clocks since reset release using plain division/modulo arithmetic.
// ---------------------------------------------------------------------------
module tb_vga_scan_driver;

    // Small raster for instance u1
    localparam int S_HA = 16, S_HFP = 3, S_HS = 5, S_HBP = 4;
    localparam int S_VA = 6,  S_VFP = 2, S_VS = 2, S_HTOT = S_HA + S_HFP + S_HS + S_HBP;
    localparam int S_VBP = 3;
    localparam int S_VTOT = S_VA + S_VFP + S_VS + S_VBP;
    localparam bit S_POL = 1'b0;

    typedef struct packed {
        logic [11:0] h;
        logic [11:0] v;
        logic [11:0] col;
        logic        cv;
        logic        hs;
        logic        vs;
        logic        fs;
        logic        rst;
    } exp_t;

    logic        clk = 1'b1;
    logic        rst_n = 1'b0;
    logic [11:0] pd = 12'h000;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vga_scan_driver_if if0();
    vga_scan_driver_if if1();

    logic [3:0] r0, g0, b0, r1, g1, b1;
    logic       hs0, vs0, hs1, vs1;

    vga_scan_driver u0 (
        .CLK100MHZ (clk), .CPU_RESETN (rst_n), .pix_if (if0.master),
        .VGA_R (r0), .VGA_G (g0), .VGA_B (b0), .VGA_HS (hs0), .VGA_VS (vs0)
    );

    vga_scan_driver #(
        .H_ACTIVE (S_HA), .H_FP (S_HFP), .H_SYNC (S_HS), .H_BP (S_HBP),
        .V_ACTIVE (S_VA), .V_FP (S_VFP), .V_SYNC (S_VS), .V_BP (S_VBP),
        .SYNC_POL (S_POL)
    ) u1 (
        .CLK100MHZ (clk), .CPU_RESETN (rst_n), .pix_if (if1.master),
        .VGA_R (r1), .VGA_G (g1), .VGA_B (b1), .VGA_HS (hs1), .VGA_VS (vs1)
    );

    // -------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------
    function automatic exp_t rst_exp(input bit pol);
        exp_t e;
        e.h = 12'd0; e.v = 12'd0; e.col = 12'h000; e.cv = 1'b1;
        e.hs = ~pol; e.vs = ~pol; e.fs = 1'b0; e.rst = 1'b1;
        return e;
    endfunction

    // k = clocks since release. Pixel p = k/2 is on the counters; the pins
    // show pixel p-1, refreshed on even k using the colour driven then.
    function automatic exp_t model(input int k, input int ha, input int hfp,
                                   input int hsw, input int hbp, input int va,
                                   input int vfp, input int vsw, input int vbp,
                                   input bit pol, input logic [11:0] d,
                                   input exp_t prev);
        exp_t e;
        int ht, vt, p, q, qh, qv;
        bit vis;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        p  = k / 2;
        e.h   = 12'((p % ht));
        e.v   = 12'(((p / ht) % vt));
        e.cv  = ((p % ht) < ha) && (((p / ht) % vt) < va);
        e.rst = 1'b0;
        e.col = prev.col; e.hs = prev.hs; e.vs = prev.vs; e.fs = 1'b0;
        if ((k % 2 == 0) && (k > 0)) begin
            q   = p - 1;
            qh  = q % ht;
            qv  = (q / ht) % vt;
            vis = (qh < ha) && (qv < va);
            e.col = vis ? d : 12'h000;
`ifdef VGA_BORDER_EN
            if (vis && (qh == 0 || qh == ha - 1 || qv == 0 || qv == va - 1))
                e.col = 12'hFFF;
`endif
            e.hs = (qh >= ha + hfp && qh < ha + hfp + hsw) ? pol : ~pol;
            e.vs = (qv >= va + vfp && qv < va + vfp + vsw) ? pol : ~pol;
            e.fs = (p % (ht * vt)) == 0;
        end
        return e;
    endfunction

    // -------------------------------------------------------------------
    // Stimulus: drives one cycle and pushes the expected post-edge state
    // -------------------------------------------------------------------
    exp_t q0[$];
    exp_t q1[$];
    exp_t last0, last1;
    int   k = 0;

    task automatic step(input bit r, input logic [11:0] d);
        @(negedge clk);
        rst_n = r;
        pd = d;
        if0.pixel_data = d;
        if1.pixel_data = d;
        if (!r) begin
            k = 0;
            last0 = rst_exp(1'b1);
            last1 = rst_exp(S_POL);
        end else begin
            k = k + 1;
            last0 = model(k, 800, 56, 120, 64, 600, 37, 6, 23, 1'b1, d, last0);
            last1 = model(k, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP,
                          S_POL, d, last1);
        end
        q0.push_back(last0);
        q1.push_back(last1);
    endtask

    // mode 0: random colour, 1: constant A5C, 2: black
    function automatic logic [11:0] pick(input int mode);
        if (mode == 1) return 12'hA5C;
        if (mode == 2) return 12'h000;
        return 12'($urandom_range(0, 4095));
    endfunction

    task automatic run(input int n, input int mode);
        for (int i = 0; i < n; i++) step(1'b1, pick(mode));
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------
    // Monitors: pop one expectation per clock and compare all outputs
    // -------------------------------------------------------------------
    exp_t        m0, m1;
    logic [11:0] ph0 = 12'd0;
    logic        phs0 = 1'b0, pvs1 = 1'b0;
    int          lz0 = -1, hr0 = -1, lf1 = -1, vr1 = -1;

    always begin
        @(posedge clk);
        #1;
        if (q0.size() > 0) begin
            m0 = q0.pop_front();
            chk("u0_hindex", int'(if0.Hindex), int'(m0.h));
            chk("u0_vindex", int'(if0.Vindex), int'(m0.v));
            chk("u0_canvas_valid", int'(if0.canvas_valid), int'(m0.cv));
            chk("u0_colour", int'({r0, g0, b0}), int'(m0.col));
            chk("u0_hs", int'(hs0), int'(m0.hs));
            chk("u0_vs", int'(vs0), int'(m0.vs));
            chk("u0_frame_start", int'(if0.frame_start), int'(m0.fs));
            if (m0.rst) begin
                lz0 = -1; hr0 = -1;
            end else begin
                if (if0.Hindex == 12'd0 && ph0 != 12'd0) begin
                    if (lz0 >= 0) chk("u0_line_period", cyc - lz0, 2080);
                    lz0 = cyc;
                end
                if (hs0 && !phs0) hr0 = cyc;
                if (!hs0 && phs0 && hr0 >= 0) chk("u0_hs_width", cyc - hr0, 240);
            end
            ph0 = if0.Hindex;
            phs0 = hs0;
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (q1.size() > 0) begin
            m1 = q1.pop_front();
            chk("u1_hindex", int'(if1.Hindex), int'(m1.h));
            chk("u1_vindex", int'(if1.Vindex), int'(m1.v));
            chk("u1_canvas_valid", int'(if1.canvas_valid), int'(m1.cv));
            chk("u1_colour", int'({r1, g1, b1}), int'(m1.col));
            chk("u1_hs", int'(hs1), int'(m1.hs));
            chk("u1_vs", int'(vs1), int'(m1.vs));
            chk("u1_frame_start", int'(if1.frame_start), int'(m1.fs));
            if (m1.rst) begin
                lf1 = -1; vr1 = -1;
            end else begin
                if (if1.frame_start) begin
                    if (lf1 >= 0) chk("u1_frame_period", cyc - lf1, 2 * S_HTOT * S_VTOT);
                    lf1 = cyc;
                end
                if ((vs1 == S_POL) && (pvs1 != S_POL)) vr1 = cyc;
                if ((vs1 != S_POL) && (pvs1 == S_POL) && vr1 >= 0)
                    chk("u1_vs_width", cyc - vr1, 2 * S_HTOT * S_VS);
            end
            pvs1 = vs1;
        end
    end

    // -------------------------------------------------------------------
    // Test sequence
    // -------------------------------------------------------------------
    initial begin
        int guard;
        last0 = rst_exp(1'b1);
        last1 = rst_exp(S_POL);
        if0.pixel_data = 12'h000;
        if1.pixel_data = 12'h000;

        for (int i = 0; i < 5; i++) step(1'b0, pick(0));   // reset values
        run(2100, 1);                                       // constant A5C line
        run(4300, 0);                                       // random colours

        // Reset while u0 sits at Hindex 900 (inside HSYNC)
        guard = 0;
        while (last0.h != 12'd900 && guard < 3000) begin
            step(1'b1, pick(0));
            guard++;
        end
        if (last0.h != 12'd900) begin
            errors++;
            $display("FAIL reach_h900 timeout actual=%0d expected=900", last0.h);
        end
        step(1'b0, pick(0));

        run(2300, 0);                                       // several small frames
        run(800, 2);                                        // black input: border check
        run(300, 0);
        step(1'b0, pick(0));                                // mid-frame reset
        step(1'b0, pick(0));
        run(100, 0);

        @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
